// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    NONE  = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the execute-stage control and the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             start_i;
  mdu_op_t          op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  hi_o, lo_o, busy_o, stall_o, done_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output hi_o, lo_o, busy_o, stall_o, done_o
  );

endinterface

// File: rtl/mul_div_unit_iter_datapath.sv
// One combinational iteration: shift-add multiply or restoring-divide step on a 2*WIDTH+1 accumulator.
module mdu_iter_datapath #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_cur,
  input  logic [WIDTH-1:0] operand,
  input  logic             div_mode,
  output logic [2*WIDTH:0] acc_nxt
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub_diff;
  logic [2*WIDTH:0] shl;

  always_comb begin
    // Multiply: {carry, partial product, remaining multiplier bits}, shifted right each step.
    add_sum  = acc_cur[2*WIDTH:WIDTH] + (acc_cur[0] ? {1'b0, operand} : '0);
    // Divide: {remainder, quotient}, shifted left; the top bit of the difference is the borrow.
    shl      = {acc_cur[2*WIDTH-1:0], 1'b0};
    trial    = shl[2*WIDTH:WIDTH];
    sub_diff = trial - {1'b0, operand};
    if (div_mode) begin
      acc_nxt = shl;
      if (!sub_diff[WIDTH]) begin
        acc_nxt = {sub_diff, shl[WIDTH-1:1], 1'b1};
      end
    end else begin
      acc_nxt = {1'b0, add_sum, acc_cur[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// WIDTH iterations plus one sign fix-up cycle; stalls fetch while an operation is in flight.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2*WIDTH + 1;

  mdu_state_t       state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nxt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             div0;
  logic             done;

  logic             issue_md;
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign issue_md  = bus.start_i && (bus.op_i inside {MULT, MULTU, DIV, DIVU});
  assign op_signed = (bus.op_i == MULT) || (bus.op_i == DIV);
  assign a_neg     = op_signed && bus.a_i[WIDTH-1];
  assign b_neg     = op_signed && bus.b_i[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag     = b_neg ? -bus.b_i : bus.b_i;

  mdu_iter_datapath #(.WIDTH(WIDTH)) u_step (
    .acc_cur  (acc),
    .operand  (opnd),
    .div_mode (is_div),
    .acc_nxt  (acc_nxt)
  );

  // Divide leaves quotient in the low half and remainder in the high half of the same accumulator.
  assign prod     = acc[2*WIDTH-1:0];
  assign prod_fix = neg_lo ? -prod : prod;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div0) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_lo = neg_lo ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        fix_hi = neg_hi ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_md) begin
            acc    <= {{(WIDTH+1){1'b0}}, a_mag};
            opnd   <= b_mag;
            a_raw  <= bus.a_i;
            is_div <= (bus.op_i == DIV) || (bus.op_i == DIVU);
            neg_lo <= a_neg ^ b_neg;
            // Remainder follows the dividend; the product follows the sign product.
            neg_hi <= (bus.op_i == DIV) ? a_neg : (a_neg ^ b_neg);
            div0   <= (bus.b_i == '0);
            cnt    <= '0;
            state  <= RUN;
          end else if (bus.start_i && bus.op_i == MTHI) begin
            hi <= bus.a_i;
          end else if (bus.start_i && bus.op_i == MTLO) begin
            lo <= bus.a_i;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi_o    = hi;
  assign bus.lo_o    = lo;
  assign bus.busy_o  = (state != IDLE);
  assign bus.stall_o = (state != IDLE) || issue_md;
  assign bus.done_o  = done;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS core.
- Sits beside the ALU in the execute stage and consumes the same A/B operands.
- Its HI/LO outputs feed the writeback select for mfhi/mflo.
- Drives a stall to fetch while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  issue strobe from control unit, one cycle per instruction
op_i  in  3  mdu_op_t: NONE=0 MULT=1 MULTU=2 DIV=3 DIVU=4 MTHI=5 MTLO=6
a_i  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
b_i  in  WIDTH  rt operand (multiplier / divisor)
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register
busy_o  out  1  operation in flight
stall_o  out  1  hold fetch/PC; combinational: busy_o OR (start_i AND op_i in MULT..DIVU)
done_o  out  1  one-cycle pulse after HI/LO update by MULT/DIV ops

Behaviour:
- Reset, async, any state: state=IDLE; hi_o=0, lo_o=0, busy_o=0, done_o=0; counter and datapath cleared. Reset mid-operation abandons it, with no partial HI/LO write.
- States: IDLE, RUN, FIX.
- IDLE:
  - start_i=1 with op MULT..DIVU: latch operands, go to RUN, counter=0.
    - Signed ops latch magnitudes of a_i/b_i plus the two sign bits.
    - Unsigned ops latch raw values.
  - start_i=1 with MTHI/MTLO: write a_i to HI/LO at that edge. No busy, no done.
  - op NONE or start_i=0: no action.
- RUN:
  - One iteration per cycle, WIDTH cycles; counter increments, and the last iteration goes to FIX.
  - Multiply: shift-add on a 2*WIDTH product accumulator.
  - Divide: restoring, one quotient bit per cycle into a WIDTH remainder/quotient pair.
- FIX, one cycle:
  - Apply sign correction.
  - Write HI/LO. Multiply: HI=product[2W-1:W], LO=product[W-1:0]. Divide: LO=quotient, HI=remainder.
  - Return to IDLE; done_o=1 the following cycle.
- Timing:
  - busy_o rises after the start edge and falls after the FIX edge, so it is high WIDTH+1 cycles (33 at default).
  - New HI/LO are visible WIDTH+1 cycles after the start edge.
- Signed rules:
  - Product negated if signs differ.
  - Quotient truncates toward zero, negated if signs differ.
  - Remainder takes the sign of the dividend.
  - Overflow case, most-negative / -1: LO=most-negative, HI=0. No trap.
- Divide by zero (signed or unsigned): LO=all-ones, HI=a_i as issued. No trap.
- start_i while busy_o=1: ignored, including MTHI/MTLO. Control guarantees this does not happen because of stall_o; the bench checks it is harmless.
- hi_o/lo_o hold the previous values throughout RUN/FIX.
- MTHI/MTLO take effect the cycle after the start edge.
- done_o deasserts after one cycle.
- All state is in a single always_ff on posedge clk / posedge rst. Output widths are exactly WIDTH; no implicit truncation of the 2*WIDTH product except the defined HI/LO split.

Decomposition:
- Shared package mdu_pkg holds:
  - mdu_op_t enum (values above).
  - mdu_state_t enum {IDLE, RUN, FIX}.
  - Localparam MDU_OP_W=3.
- One sub-module, mdu_iter_datapath: per-iteration shift-add / restore-subtract step.
  - Inputs: current accumulator, operand, and mode.
  - Outputs: next accumulator.
  - Purely combinational.
- The FSM, counter, sign fix-up and HI/LO registers stay in mul_div_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall_o high on the start cycle and busy_o high 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001, done_o one pulse.
- MULT a=0xFFFFFFFD(-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB(-21).
- DIV a=0xFFFFFFF9(-7) b=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100 b=0 -> LO=0xFFFFFFFF, HI=100. DIVU a=100 b=7 -> LO=14, HI=2.
- MTHI a=0x1234 then MTLO a=0xABCD on back-to-back cycles -> hi_o=0x1234 and lo_o=0xABCD, each one cycle after its issue; busy_o stays 0.
- Robustness:
  - Start MULTU 5*6.
  - At cycle 10, assert start_i with DIV a=9 b=3; it must be ignored, giving final HI=0, LO=30.
  - Repeat the run and assert rst at cycle 20. Required: busy_o=0, hi_o=0, lo_o=0 immediately, no done_o pulse.
